// File: rtl/adc_sample_averager.sv
// Windowed mean of a 2-bit flash-ADC code stream with a one-deep ready/valid result register.
// Defining ADC_AVG_MINMAX_EN adds per-window min/max tracking on min_out/max_out.
module adc_sample_averager #(
  parameter int WINDOW_LOG2 = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       sample_en,
  input  logic [1:0] code_in,
  input  logic       out_ready,
  input  logic       overrun_clr,
  output logic       out_valid,
  output logic [3:0] avg_out,
  output logic       overrun,
  output logic [1:0] min_out,
  output logic [1:0] max_out
);

  localparam int W = WINDOW_LOG2;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_ACCUM = 1'b1;

  logic           state_q, state_d;
  logic [W+1:0]   sum_q, sum_d;
  logic [W-1:0]   count_q, count_d;
  logic           out_valid_q, out_valid_d;
  logic [3:0]     avg_q, avg_d;
  logic           overrun_q, overrun_d;

  logic           accumulating;
  logic           accept;
  logic           complete;
  logic           load;
  logic           drop;
  logic [W+1:0]   final_sum;

  // A sample counts only when the engine was already in ACCUM and enable is still high,
  // so the edges entering and leaving ACCUM never contribute data.
  assign accumulating = (state_q == ST_ACCUM) && enable;
  assign accept       = accumulating && sample_en;
  assign complete     = accept && (&count_q);
  assign final_sum    = sum_q + {{W{1'b0}}, code_in};
  assign load         = complete && (!out_valid_q || out_ready);
  assign drop         = complete && out_valid_q && !out_ready;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d     = enable ? ST_ACCUM : ST_IDLE;
    sum_d       = sum_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    avg_d       = avg_q;
    overrun_d   = overrun_q;

    if (!accumulating) begin
      sum_d   = '0;
      count_d = '0;
    end else if (accept) begin
      if (complete) begin
        sum_d   = '0;
        count_d = '0;
      end else begin
        sum_d   = final_sum;
        count_d = count_q + 1'b1;
      end
    end

    if (load) begin
      out_valid_d = 1'b1;
      avg_d       = final_sum[W+1:W-2];
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    // A drop on the same edge as a clear keeps the flag set.
    if (drop) begin
      overrun_d = 1'b1;
    end else if (overrun_clr) begin
      overrun_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      sum_q       <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      avg_q       <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      avg_q       <= avg_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_valid = out_valid_q;
  assign avg_out   = avg_q;
  assign overrun   = overrun_q;

`ifdef ADC_AVG_MINMAX_EN
  logic [1:0] run_min_q, run_min_d;
  logic [1:0] run_max_q, run_max_d;
  logic [1:0] min_q, min_d;
  logic [1:0] max_q, max_d;
  logic [1:0] sample_min;
  logic [1:0] sample_max;

  // Extremes including the current sample, so the completing sample is reflected in the latch.
  assign sample_min = (code_in < run_min_q) ? code_in : run_min_q;
  assign sample_max = (code_in > run_max_q) ? code_in : run_max_q;

  always_comb begin
    run_min_d = run_min_q;
    run_max_d = run_max_q;
    min_d     = min_q;
    max_d     = max_q;

    if (!accumulating || complete) begin
      run_min_d = 2'd3;
      run_max_d = 2'd0;
    end else if (accept) begin
      run_min_d = sample_min;
      run_max_d = sample_max;
    end

    if (load) begin
      min_d = sample_min;
      max_d = sample_max;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      run_min_q <= 2'd3;
      run_max_q <= 2'd0;
      min_q     <= 2'd0;
      max_q     <= 2'd0;
    end else begin
      run_min_q <= run_min_d;
      run_max_q <= run_max_d;
      min_q     <= min_d;
      max_q     <= max_d;
    end
  end

  assign min_out = min_q;
  assign max_out = max_q;
`else
  assign min_out = 2'b00;
  assign max_out = 2'b00;
`endif

endmodule

// File: tb/tb_adc_sample_averager.sv
// Scoreboard bench for adc_sample_averager (WINDOW_LOG2=4); min/max expectations follow ADC_AVG_MINMAX_EN.
module tb_adc_sample_averager;

  typedef struct packed {
    logic [3:0] avg;
    logic [1:0] mn;
    logic [1:0] mx;
  } res_t;

`ifdef ADC_AVG_MINMAX_EN
  localparam bit MM = 1'b1;
`else
  localparam bit MM = 1'b0;
`endif

  logic       clk;
  logic       reset_n;
  logic       enable;
  logic       sample_en;
  logic [1:0] code_in;
  logic       out_ready;
  logic       overrun_clr;
  logic       out_valid;
  logic [3:0] avg_out;
  logic       overrun;
  logic [1:0] min_out;
  logic [1:0] max_out;

  int   total = 0;
  int   bad   = 0;
  res_t exp_q[$];

  adc_sample_averager #(.WINDOW_LOG2(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .sample_en   (sample_en),
    .code_in     (code_in),
    .out_ready   (out_ready),
    .overrun_clr (overrun_clr),
    .out_valid   (out_valid),
    .avg_out     (avg_out),
    .overrun     (overrun),
    .min_out     (min_out),
    .max_out     (max_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic res_t mk(input logic [3:0] avg, input logic [1:0] lo, input logic [1:0] hi);
    res_t r;
    r.avg = avg;
    r.mn  = MM ? lo : 2'd0;
    r.mx  = MM ? hi : 2'd0;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [1:0] code, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      sample_en = 1'b1;
      code_in   = code;
      tick();
      sample_en = 1'b0;
      for (int g = 0; g < gap; g++) tick();
    end
  endtask

  // Consumption happens on the next rising edge; compare against the oldest expected result.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'd1, 32'd0);
      end else begin
        res_t e;
        e = exp_q.pop_front();
        check("sb_avg", avg_out, e.avg);
        check("sb_min", min_out, e.mn);
        check("sb_max", max_out, e.mx);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n     = 1'b0;
    enable      = 1'b0;
    sample_en   = 1'b0;
    code_in     = 2'd0;
    out_ready   = 1'b0;
    overrun_clr = 1'b0;
    tick();
    tick();
    check("rst_valid", out_valid, 0);
    check("rst_avg", avg_out, 0);
    check("rst_overrun", overrun, 0);
    check("rst_min", min_out, 0);
    check("rst_max", max_out, 0);

    reset_n = 1'b1;
    enable  = 1'b1;
    tick();

    // Constant code 2: mean 2.00, single-cycle valid pulse under out_ready.
    out_ready = 1'b1;
    exp_q.push_back(mk(4'b1000, 2'd2, 2'd2));
    feed(2'd2, 16, 0);
    check("t1_valid_hi", out_valid, 1);
    tick();
    check("t1_valid_pulse", out_valid, 0);
    check("t1_overrun", overrun, 0);

    // Half 3s, half 0s with idle gaps: mean 1.50.
    exp_q.push_back(mk(4'b0110, 2'd0, 2'd3));
    feed(2'd3, 8, 2);
    feed(2'd0, 8, 2);
    check("t2_valid_done", out_valid, 0);

    // Stalled consumer: second window dropped, first retained.
    out_ready = 1'b0;
    exp_q.push_back(mk(4'b0100, 2'd1, 2'd1));
    feed(2'd1, 16, 0);
    check("t3_valid", out_valid, 1);
    check("t3_avg_first", avg_out, 4'b0100);
    feed(2'd1, 16, 0);
    check("t3_overrun_set", overrun, 1);
    check("t3_avg_kept", avg_out, 4'b0100);
    check("t3_valid_kept", out_valid, 1);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    check("t3_overrun_clr", overrun, 0);

    // Handshake coincides with the next completion: new result loads, no overrun.
    feed(2'd3, 15, 0);
    out_ready = 1'b1;
    exp_q.push_back(mk(4'b1100, 2'd3, 2'd3));
    feed(2'd3, 1, 0);
    check("t4_valid_stays", out_valid, 1);
    check("t4_avg_new", avg_out, 4'b1100);
    check("t4_overrun", overrun, 0);
    tick();
    check("t4_valid_done", out_valid, 0);

    // Partial window discarded by dropping enable.
    feed(2'd3, 10, 0);
    enable = 1'b0;
    tick();
    tick();
    enable = 1'b1;
    tick();
    exp_q.push_back(mk(4'b0100, 2'd1, 2'd1));
    feed(2'd1, 16, 0);
    tick();
    check("t5_valid_done", out_valid, 0);

    // Reset mid-window with a result pending.
    out_ready = 1'b0;
    feed(2'd2, 16, 0);
    check("t6_pending_valid", out_valid, 1);
    check("t6_pending_avg", avg_out, 4'b1000);
    feed(2'd1, 5, 0);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_avg", avg_out, 0);
    check("t6_rst_overrun", overrun, 0);
    check("t6_rst_min", min_out, 0);
    check("t6_rst_max", max_out, 0);
    tick();
    exp_q.push_back(mk(4'b0000, 2'd0, 2'd0));
    feed(2'd0, 16, 0);
    check("t6_valid", out_valid, 1);
    check("t6_avg", avg_out, 0);
    out_ready = 1'b1;
    tick();
    check("t6_valid_done", out_valid, 0);

    check("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
